tinyalu_core: RTL and testbench

Synthesizable TinyALU responder: the DUT end of the start/done operation protocol driven by the ALU BFM. It captures two unsigned 8-bit operands and a 3-bit opcode on `start` and computes add, and, xor or multiply. It returns a 16-bit `result` with a one-cycle `done` pulse, and sits directly behind the BFM pins in the top-level testbench.

---
 rtl/tinyalu_core.sv | 170 +++++++++++++++++
 tb/tb_tinyalu_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_core.sv
// ----------------------------------------------------------------------------
// tinyalu_core
//
// DUT side of the TinyALU start/done protocol. Two unsigned 8-bit operands
// and a 3-bit opcode are captured when `start` is seen in IDLE. The block
// returns a registered 16-bit `result` with a one-cycle `done` pulse.
//
// Opcodes: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 111 rst_op.
// 101 and 110 are unused. no_op, rst_op and the unused codes never raise
// `done`.
//
// Configuration macro: TINYALU_MUL_PIPE_EN
//   defined   : multiply runs through a 3-stage registered pipeline
//               (operand, product and output registers), so `done` comes
//               3 cycles after launch.
//   undefined : multiply is combinational off the captured operands and
//               completes in 1 cycle, like add/and/xor.
//
// Ports:
//   clk      in   1  clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   A        in   8  operand A (unsigned)
//   B        in   8  operand B (unsigned)
//   op       in   3  opcode
//   start    in   1  request, held high by the initiator until done
//   done     out  1  one-cycle pulse, result valid
//   result   out 16  registered result, holds between operations
// ----------------------------------------------------------------------------
module tinyalu_core (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result
);

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_MUL,
        ST_RELEASE
    } state_t;

    state_t      state_reg;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [2:0]  op_reg;
    logic [15:0] single_res;
    logic [8:0]  sum9;

`ifdef TINYALU_MUL_PIPE_EN
    logic [1:0]  stage_cnt_reg;
    logic [15:0] prod_reg;
    logic [15:0] mul_out_reg;
`endif

    // Single-cycle results are formed from the captured operands only, so
    // input changes after launch cannot leak into the result.
    assign sum9 = {1'b0, a_reg} + {1'b0, b_reg};

    always_comb begin
        single_res = 16'h0000;
        case (op_reg)
            OP_ADD: single_res = {7'b0, sum9};
            OP_AND: single_res = {8'b0, a_reg & b_reg};
            OP_XOR: single_res = {8'b0, a_reg ^ b_reg};
`ifndef TINYALU_MUL_PIPE_EN
            OP_MUL: single_res = {8'b0, a_reg} * {8'b0, b_reg};
`endif
            default: single_res = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            a_reg         <= 8'h00;
            b_reg         <= 8'h00;
            op_reg        <= 3'b000;
            done          <= 1'b0;
            result        <= 16'h0000;
`ifdef TINYALU_MUL_PIPE_EN
            stage_cnt_reg <= 2'd0;
            prod_reg      <= 16'h0000;
            mul_out_reg   <= 16'h0000;
`endif
        end else begin
            // done is a pulse: it is raised only in the completing cycle
            done <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_reg  <= A;
                        b_reg  <= B;
                        op_reg <= op;
                        case (op)
                            OP_ADD, OP_AND, OP_XOR: state_reg <= ST_SINGLE;
                            OP_MUL: begin
`ifdef TINYALU_MUL_PIPE_EN
                                state_reg     <= ST_MUL;
                                stage_cnt_reg <= 2'd0;
`else
                                state_reg     <= ST_SINGLE;
`endif
                            end
                            // no_op, rst_op and unused codes: wait for start
                            // to drop without producing anything
                            default: state_reg <= ST_RELEASE;
                        endcase
                    end
                end

                ST_SINGLE: begin
                    if (start) begin
                        result    <= single_res;
                        done      <= 1'b1;
                        state_reg <= ST_RELEASE;
                    end else begin
                        // initiator withdrew the request: silent abort
                        state_reg <= ST_IDLE;
                    end
                end

                ST_MUL: begin
`ifdef TINYALU_MUL_PIPE_EN
                    if (start) begin
                        prod_reg    <= {8'b0, a_reg} * {8'b0, b_reg};
                        mul_out_reg <= prod_reg;
                        // stage 1 (operands) was filled at launch; after the
                        // product and output stages the result is retired
                        if (stage_cnt_reg == 2'd2) begin
                            result    <= mul_out_reg;
                            done      <= 1'b1;
                            state_reg <= ST_RELEASE;
                        end else begin
                            stage_cnt_reg <= stage_cnt_reg + 2'd1;
                        end
                    end else begin
                        prod_reg      <= 16'h0000;
                        mul_out_reg   <= 16'h0000;
                        stage_cnt_reg <= 2'd0;
                        state_reg     <= ST_IDLE;
                    end
`else
                    state_reg <= ST_IDLE;
`endif
                end

                ST_RELEASE: begin
                    // never retrigger while start stays high
                    if (!start) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_core.sv
// ----------------------------------------------------------------------------
// tb_tinyalu_core
//
// Self-checking bench for tinyalu_core. Each scenario is a task that drives
// the start/done protocol and compares against expectations computed from
// plain arithmetic on the operands. Inputs are driven and outputs sampled
// 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_tinyalu_core;

`ifdef TINYALU_MUL_PIPE_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = 1;
`endif

    logic        clk;
    logic        reset_n;
    logic [7:0]  a_drv;
    logic [7:0]  b_drv;
    logic [2:0]  op_drv;
    logic        start;
    logic        done;
    logic [15:0] result;

    int          n_cmp;
    int          n_bad;
    logic [15:0] exp_result;

    tinyalu_core dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (a_drv),
        .B       (b_drv),
        .op      (op_drv),
        .start   (start),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request and check done count, done latency and result.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] o, input int extra_hold,
                         input bit scramble, input string tag);
        logic [15:0] want;
        bit          has_done;
        int          lat;
        int          dones;
        int          first_at;
        int          window;
        want     = exp_result;
        has_done = 1'b1;
        lat      = 1;
        case (o)
            3'd1: want = 16'(a) + 16'(b);
            3'd2: want = 16'(a & b);
            3'd3: want = 16'(a ^ b);
            3'd4: begin want = 16'(a) * 16'(b); lat = MUL_LAT; end
            default: has_done = 1'b0;
        endcase
        window = has_done ? (lat + extra_hold + 4) : 8;

        a_drv = a; b_drv = b; op_drv = o; start = 1'b1;
        @(posedge clk); #1;                      // launch edge k
        if (scramble) begin a_drv = 8'h00; b_drv = 8'h00; end
        if (!has_done) start = 1'b0;
        dones = 0; first_at = -1;
        for (int i = 1; i <= window; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                if (first_at < 0) first_at = i;
            end
            if (has_done && i == lat + extra_hold) start = 1'b0;
        end

        n_cmp++;
        if (dones != (has_done ? 1 : 0)) begin
            n_bad++;
            $display("FAIL %s done_count: got %0d expected %0d", tag, dones, has_done ? 1 : 0);
        end
        if (has_done) begin
            n_cmp++;
            if (first_at != lat) begin
                n_bad++;
                $display("FAIL %s done_latency: got %0d expected %0d", tag, first_at, lat);
            end
        end
        n_cmp++;
        if (result !== want) begin
            n_bad++;
            $display("FAIL %s result: got %h expected %h", tag, result, want);
        end
        $display("op %s A=%h B=%h op=%0d result=%h dones=%0d", tag, a, b, o, result, dones);
        exp_result = want;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0;
        a_drv = 8'h00; b_drv = 8'h00; op_drv = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++;
        if (result !== 16'h0000) begin n_bad++; $display("FAIL reset_result: got %h expected 0000", result); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL idle_done: got %b expected 0", done); end
        exp_result = 16'h0000;
        $display("reset done=%b result=%h", done, result);
    endtask

    task automatic test_add_hold();
        do_op(8'hFF, 8'hFF, 3'd1, 4, 1'b0, "add_hold");
        n_cmp++;
        if (result !== 16'h01FE) begin n_bad++; $display("FAIL add_ff_ff: got %h expected 01FE", result); end
    endtask

    task automatic test_and_xor();
        do_op(8'hAA, 8'h0F, 3'd2, 0, 1'b0, "and");
        n_cmp++;
        if (result !== 16'h000A) begin n_bad++; $display("FAIL and_const: got %h expected 000A", result); end
        do_op(8'hAA, 8'hFF, 3'd3, 0, 1'b0, "xor");
        n_cmp++;
        if (result !== 16'h0055) begin n_bad++; $display("FAIL xor_const: got %h expected 0055", result); end
    endtask

    task automatic test_mul();
        do_op(8'hFF, 8'hFF, 3'd4, 0, 1'b1, "mul_scramble");
        n_cmp++;
        if (result !== 16'hFE01) begin n_bad++; $display("FAIL mul_ff_ff: got %h expected FE01", result); end
    endtask

    task automatic test_noop();
        do_op(8'h12, 8'h34, 3'd0, 0, 1'b0, "noop");
    endtask

    task automatic test_reset_mid_mul();
        int dones;
        a_drv = 8'hFF; b_drv = 8'hFF; op_drv = 3'd4; start = 1'b1;
        @(posedge clk); #1;                      // edge k
        @(posedge clk); #3;                      // mid-cycle after k+1
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL async_rst_done: got %b expected 0", done); end
        n_cmp++;
        if (result !== 16'h0000) begin n_bad++; $display("FAIL async_rst_result: got %h expected 0000", result); end
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_result = 16'h0000;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin n_bad++; $display("FAIL post_rst_done: got %0d expected 0", dones); end
        $display("reset_mid_mul result=%h dones=%0d", result, dones);
        do_op(8'h01, 8'h01, 3'd1, 0, 1'b0, "add_after_rst");
        n_cmp++;
        if (result !== 16'h0002) begin n_bad++; $display("FAIL add_1_1: got %h expected 0002", result); end
    endtask

    task automatic test_abort();
        int dones;
        a_drv = 8'h37; b_drv = 8'h05; op_drv = 3'd4; start = 1'b1;
        @(posedge clk); #1;                      // edge k
        start = 1'b0;                            // sampled low at k+1
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin n_bad++; $display("FAIL abort_done: got %0d expected 0", dones); end
        n_cmp++;
        if (result !== exp_result) begin n_bad++; $display("FAIL abort_result: got %h expected %h", result, exp_result); end
        $display("abort result=%h dones=%0d", result, dones);
        do_op(8'h80, 8'h81, 3'd1, 0, 1'b0, "add_after_abort");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            do_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                  int'($urandom_range(0, 2)), 1'($urandom), "rand");
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; exp_result = 16'h0000;
        test_reset();
        test_add_hold();
        test_and_xor();
        test_mul();
        test_noop();
        test_reset_mid_mul();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
